// File: rtl/port_rx_pkg.sv
// Shared defaults and helpers for the PORTE receive path.
package port_rx_pkg;
  localparam int WIDTH_DEFAULT = 8;
  localparam int DEPTH_DEFAULT = 4;

  // FIFO pointers carry one bit beyond the address so full and empty differ.
  function automatic int ptr_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a bus of level signals; both stages reset to 0.
module sync_2ff #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  logic [WIDTH-1:0] r_s1;
  logic [WIDTH-1:0] r_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
    end
  end

  assign o_q = r_s2;
endmodule

// File: rtl/port_e_receiver.sv
// Host PORTE receiver: synchronises data and toggle tag, accepts one byte per
// tag change into a FWFT FIFO and returns an acknowledge tag to the host.
module port_e_receiver
  import port_rx_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT,
  parameter int DEPTH = DEPTH_DEFAULT
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [WIDTH-1:0]       port_e,
  input  logic                   tag_in,
  output logic [WIDTH-1:0]       out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   ack_tag,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [7:0]             accepted_count
);
  localparam int PW = ptr_width(DEPTH);
  localparam int AW = PW - 1;

  logic [WIDTH:0]   w_sync;
  logic             w_s2_tag;
  logic [WIDTH-1:0] w_s2_data;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wptr;
  logic [PW-1:0]    r_rptr;
  logic             r_prev_tag;
  logic [7:0]       r_accepted_count;

  logic [PW-1:0]    w_level;
  logic             w_full;
  logic             w_empty;
  logic             w_pending;
  logic             w_pop;
  logic             w_accept;

  sync_2ff #(.WIDTH(WIDTH + 1)) u_sync (
    .clk (clock),
    .rst (reset),
    .i_d ({tag_in, port_e}),
    .o_q (w_sync)
  );

  assign w_s2_tag  = w_sync[WIDTH];
  assign w_s2_data = w_sync[WIDTH-1:0];

  assign w_level   = r_wptr - r_rptr;
  assign w_full    = (w_level == PW'(DEPTH));
  assign w_empty   = (w_level == '0);
  assign w_pending = (w_s2_tag != r_prev_tag);
  assign w_pop     = !w_empty && out_ready;
  // A pop in the same edge frees the slot, so a full FIFO can still accept.
  assign w_accept  = w_pending && (!w_full || w_pop);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_wptr           <= '0;
      r_rptr           <= '0;
      r_prev_tag       <= 1'b0;
      r_accepted_count <= '0;
    end else begin
      if (w_accept) begin
        r_wptr           <= r_wptr + PW'(1);
        r_prev_tag       <= w_s2_tag;
        r_accepted_count <= r_accepted_count + 8'd1;
      end
      if (w_pop) begin
        r_rptr <= r_rptr + PW'(1);
      end
    end
  end

  // Storage is not reset; the head is masked to zero while empty.
  always_ff @(posedge clock) begin
    if (w_accept) begin
      r_mem[r_wptr[AW-1:0]] <= w_s2_data;
    end
  end

  assign out_data       = w_empty ? '0 : r_mem[r_rptr[AW-1:0]];
  assign out_valid      = !w_empty;
  assign ack_tag        = r_prev_tag;
  assign fifo_level     = w_level;
  assign accepted_count = r_accepted_count;
endmodule

// File: tb/tb_port_e_receiver.sv
// Directed bench for port_e_receiver with a queue scoreboard on popped bytes.
module tb_port_e_receiver;
  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clock;
  logic             reset;
  logic [WIDTH-1:0] port_e;
  logic             tag_in;
  logic [WIDTH-1:0] out_data;
  logic             out_valid;
  logic             out_ready;
  logic             ack_tag;
  logic [2:0]       fifo_level;
  logic [7:0]       accepted_count;

  int n_checks = 0;
  int n_errors = 0;
  logic [WIDTH-1:0] exp_q[$];

  port_e_receiver #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clock          (clock),
    .reset          (reset),
    .port_e         (port_e),
    .tag_in         (tag_in),
    .out_data       (out_data),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .ack_tag        (ack_tag),
    .fifo_level     (fifo_level),
    .accepted_count (accepted_count)
  );

  // Clock and reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", name, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge.
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Host write with ack pacing; bounded wait for the acknowledge.
  task automatic write_byte(input logic [WIDTH-1:0] b, input bit check_level);
    int waited;
    port_e = b;
    tick();
    tag_in = ~tag_in;
    exp_q.push_back(b);
    waited = 0;
    while (ack_tag !== tag_in && waited < 20) begin
      tick();
      waited++;
      if (check_level) check("level_le_1", {31'd0, fifo_level <= 3'd1}, 32'd1);
    end
    check("ack_wait", {31'd0, ack_tag}, {31'd0, tag_in});
  endtask

  // Scoreboard: a pop happens on the next rising edge when valid && ready.
  always @(negedge clock) begin
    if (!reset && out_valid === 1'b1 && out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        check("unexpected_pop", {24'd0, out_data}, 32'hffff_ffff);
      end else begin
        check("pop_data", {24'd0, out_data}, {24'd0, exp_q.pop_front()});
      end
    end
  end

  initial begin
    reset     = 1'b1;
    port_e    = '0;
    tag_in    = 1'b0;
    out_ready = 1'b0;
    tick();
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_data", {24'd0, out_data}, 32'd0);
    check("rst_ack", {31'd0, ack_tag}, 32'd0);
    check("rst_level", {29'd0, fifo_level}, 32'd0);
    check("rst_count", {24'd0, accepted_count}, 32'd0);
    reset = 1'b0;
    tick();

    // Single byte latency
    port_e = 8'h05;
    tick();
    tag_in = 1'b1;
    exp_q.push_back(8'h05);
    tick();
    tick();
    check("lat_valid_early", {31'd0, out_valid}, 32'd0);
    check("lat_ack_early", {31'd0, ack_tag}, 32'd0);
    tick();
    check("lat_valid", {31'd0, out_valid}, 32'd1);
    check("lat_data", {24'd0, out_data}, 32'h05);
    check("lat_ack", {31'd0, ack_tag}, 32'd1);
    check("lat_count", {24'd0, accepted_count}, 32'd1);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("lat_drained", {29'd0, fifo_level}, 32'd0);

    // Fill to full, then one more toggle is held off
    write_byte(8'h11, 1'b0);
    write_byte(8'h22, 1'b0);
    write_byte(8'h33, 1'b0);
    write_byte(8'h44, 1'b0);
    port_e = 8'h55;
    tick();
    tag_in = ~tag_in;
    exp_q.push_back(8'h55);
    repeat (5) tick();
    check("full_level", {29'd0, fifo_level}, 32'd4);
    check("full_ack_held", {31'd0, ack_tag}, {31'd0, ~tag_in});
    check("full_count", {24'd0, accepted_count}, 32'd5);
    check("full_head", {24'd0, out_data}, 32'h11);

    // Single pop from full admits the pending byte on the same edge
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("pop_full_level", {29'd0, fifo_level}, 32'd4);
    check("pop_full_ack", {31'd0, ack_tag}, {31'd0, tag_in});
    check("pop_full_count", {24'd0, accepted_count}, 32'd6);
    check("pop_full_head", {24'd0, out_data}, 32'h22);

    // Drain, then an extra ready while empty
    out_ready = 1'b1;
    repeat (4) tick();
    check("drain_valid", {31'd0, out_valid}, 32'd0);
    check("drain_level", {29'd0, fifo_level}, 32'd0);
    tick();
    check("empty_ready_level", {29'd0, fifo_level}, 32'd0);
    check("drain_queue", exp_q.size(), 32'd0);

    // Streaming across the pointer wrap
    for (int v = 0; v < 10; v++) write_byte(WIDTH'(v), 1'b1);
    repeat (3) tick();
    check("wrap_queue", exp_q.size(), 32'd0);
    check("wrap_count", {24'd0, accepted_count}, 32'd16);
    out_ready = 1'b0;

    // Reset with three bytes buffered and an edge pending
    write_byte(8'ha1, 1'b0);
    write_byte(8'ha2, 1'b0);
    write_byte(8'ha3, 1'b0);
    port_e = 8'ha4;
    tick();
    tag_in = ~tag_in;
    tick();
    tick();
    check("pre_rst_level", {29'd0, fifo_level}, 32'd3);
    reset = 1'b1;
    #1;
    check("mid_rst_valid", {31'd0, out_valid}, 32'd0);
    check("mid_rst_data", {24'd0, out_data}, 32'd0);
    check("mid_rst_ack", {31'd0, ack_tag}, 32'd0);
    check("mid_rst_level", {29'd0, fifo_level}, 32'd0);
    check("mid_rst_count", {24'd0, accepted_count}, 32'd0);
    exp_q.delete();
    tag_in = 1'b0;
    tick();
    reset = 1'b0;
    repeat (6) tick();
    check("post_rst_valid", {31'd0, out_valid}, 32'd0);
    check("post_rst_count", {24'd0, accepted_count}, 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
